// File: rtl/relaxed_delay_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : relaxed_delay_monitor
//  Description : Hardware twin of  trig |-> ##[MIN_DLY:MAX_DLY] resp
//                with disable iff (!rstn). Each trigger opens an independent
//                obligation tracked in an age vector; pass/fail pulses,
//                a sticky fail flag, a saturating fail counter and an
//                outstanding-obligation flag are reported, all registered.
//  Revision    : 1.0  initial release
// ============================================================================
module relaxed_delay_monitor #(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             trig,
    input  logic             resp,
    output logic             pass,
    output logic             fail,
    output logic             fail_sticky,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             pending
);

    // pend_q[d] : unsatisfied obligation opened d samples ago
    logic [MAX_DLY:1] pend_q;
    logic [MAX_DLY:1] pend_d;
    logic [MAX_DLY:1] win;
    logic             pass_q;
    logic             pass_d;
    logic             fail_q;
    logic             fail_d;
    logic             fail_sticky_q;
    logic             fail_sticky_d;
    logic [CNT_W-1:0] fail_cnt_q;
    logic [CNT_W-1:0] fail_cnt_d;
    logic             pending_q;
    logic             pending_d;
    logic             hit_old;
    logic             hit_now;
    logic             expire;

    // Evaluate trigger, response and expiry against the pre-shift vector
    always_comb begin
        win = '0;
        for (int d = 1; d <= MAX_DLY; d++) begin
            win[d] = (d >= MIN_DLY);
        end

        // One response satisfies every obligation currently in its window
        hit_old = resp && (|(pend_q & win));
        // Zero-delay window: a trigger and response in the same sample resolve at once
        hit_now = (MIN_DLY == 0) && resp && trig;
        // The oldest age is always inside the window, so only a missing resp expires it
        expire  = pend_q[MAX_DLY] && !resp;

        pend_d = '0;
        for (int d = MAX_DLY; d >= 2; d--) begin
            pend_d[d] = pend_q[d-1] && !(resp && win[d-1]);
        end
        pend_d[1] = trig && !hit_now;

        pass_d        = hit_old || hit_now;
        fail_d        = expire;
        fail_sticky_d = fail_sticky_q || expire;
        fail_cnt_d    = fail_cnt_q;
        if (expire && (fail_cnt_q != {CNT_W{1'b1}})) begin
            fail_cnt_d = fail_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        pending_d = |pend_d;
    end

    // State and output registers; reset drops all obligations silently
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_q        <= '0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_sticky_q <= 1'b0;
            fail_cnt_q    <= '0;
            pending_q     <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            fail_sticky_q <= fail_sticky_d;
            fail_cnt_q    <= fail_cnt_d;
            pending_q     <= pending_d;
        end
    end

    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_sticky = fail_sticky_q;
    assign fail_cnt    = fail_cnt_q;
    assign pending     = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_relaxed_delay_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_relaxed_delay_monitor
//  Description : Self-checking bench for relaxed_delay_monitor. Three
//                instances (1..2/8-bit, 2..3/8-bit, 1..2/2-bit counter) share
//                one stimulus stream; a timestamp-based obligation model
//                queues expected outputs per sample, and scenario tasks
//                check the specific cycles of interest.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_relaxed_delay_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn = 1'b0;
    logic trig = 1'b0;
    logic resp = 1'b0;

    logic       pass0, fail0, stk0, pend0;
    logic [7:0] cnt0;
    logic       pass1, fail1, stk1, pend1;
    logic [7:0] cnt1;
    logic       pass2, fail2, stk2, pend2;
    logic [1:0] cnt2;

    relaxed_delay_monitor #(.MIN_DLY(1), .MAX_DLY(2), .CNT_W(8)) u_d0 (
        .clk(clk), .rstn(rstn), .trig(trig), .resp(resp),
        .pass(pass0), .fail(fail0), .fail_sticky(stk0), .fail_cnt(cnt0), .pending(pend0));
    relaxed_delay_monitor #(.MIN_DLY(2), .MAX_DLY(3), .CNT_W(8)) u_d1 (
        .clk(clk), .rstn(rstn), .trig(trig), .resp(resp),
        .pass(pass1), .fail(fail1), .fail_sticky(stk1), .fail_cnt(cnt1), .pending(pend1));
    relaxed_delay_monitor #(.MIN_DLY(1), .MAX_DLY(2), .CNT_W(2)) u_d2 (
        .clk(clk), .rstn(rstn), .trig(trig), .resp(resp),
        .pass(pass2), .fail(fail2), .fail_sticky(stk2), .fail_cnt(cnt2), .pending(pend2));

    int n_checks = 0;
    int n_errors = 0;
    int samp = 0;

    typedef struct packed {
        bit [2:0]  p;
        bit [2:0]  f;
        bit [2:0]  s;
        bit [2:0]  pe;
        bit [23:0] c;
    } exp_t;

    typedef struct {
        int cfg;
        int t0;
    } obl_t;

    exp_t sb[$];
    obl_t obl[$];
    bit [2:0] m_sticky;
    int m_cnt[3];
    int cfg_min[3]  = '{1, 2, 1};
    int cfg_max[3]  = '{2, 3, 2};
    int cfg_cmax[3] = '{255, 255, 3};

    logic obs_p [3][0:64];
    logic obs_f [3][0:64];
    logic obs_s [3][0:64];
    logic obs_pe[3][0:64];
    int   obs_c [3][0:64];

    // Reference model: every obligation is a (config, trigger time) record
    task automatic model_step(input bit r, input bit tg, input bit rs, input int t, output exp_t e);
        obl_t keep[$];
        obl_t o;
        int   age;
        int   c;
        e = '0;
        if (!r) begin
            obl.delete();
            m_sticky = '0;
            m_cnt = '{0, 0, 0};
            return;
        end
        foreach (obl[i]) begin
            o = obl[i];
            c = o.cfg;
            age = t - o.t0;
            if (rs && age >= cfg_min[c] && age <= cfg_max[c]) e.p[c] = 1'b1;
            else if (age >= cfg_max[c]) e.f[c] = 1'b1;
            else keep.push_back(o);
        end
        for (int k = 0; k < 3; k++) begin
            if (tg) begin
                if (cfg_min[k] == 0 && rs) e.p[k] = 1'b1;
                else begin
                    o.cfg = k;
                    o.t0 = t;
                    keep.push_back(o);
                end
            end
            if (e.f[k]) begin
                m_sticky[k] = 1'b1;
                if (m_cnt[k] < cfg_cmax[k]) m_cnt[k]++;
            end
        end
        foreach (keep[i]) e.pe[keep[i].cfg] = 1'b1;
        obl = keep;
        e.s = m_sticky;
        e.c = {8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
    endtask

    task automatic drive(input bit r, input bit tg, input bit rs, input int t);
        exp_t e;
        @(negedge clk);
        samp = t;
        rstn = r;
        trig = tg;
        resp = rs;
        model_step(r, tg, rs, t, e);
        sb.push_back(e);
    endtask

    // Scoreboard: compare each sample's outputs just after the sampling edge
    exp_t me;
    logic [2:0]  op, of, os, ope;
    logic [23:0] oc;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            me  = sb.pop_front();
            op  = {pass2, pass1, pass0};
            of  = {fail2, fail1, fail0};
            os  = {stk2, stk1, stk0};
            ope = {pend2, pend1, pend0};
            oc  = {6'b0, cnt2, cnt1, cnt0};
            for (int c = 0; c < 3; c++) begin
                n_checks += 5;
                if (op[c] !== me.p[c]) begin
                    n_errors++;
                    $display("FAIL sb_pass cyc%0d dut%0d got %b exp %b", samp + 1, c, op[c], me.p[c]);
                end
                if (of[c] !== me.f[c]) begin
                    n_errors++;
                    $display("FAIL sb_fail cyc%0d dut%0d got %b exp %b", samp + 1, c, of[c], me.f[c]);
                end
                if (os[c] !== me.s[c]) begin
                    n_errors++;
                    $display("FAIL sb_sticky cyc%0d dut%0d got %b exp %b", samp + 1, c, os[c], me.s[c]);
                end
                if (ope[c] !== me.pe[c]) begin
                    n_errors++;
                    $display("FAIL sb_pending cyc%0d dut%0d got %b exp %b", samp + 1, c, ope[c], me.pe[c]);
                end
                if (oc[c*8 +: 8] !== me.c[c*8 +: 8]) begin
                    n_errors++;
                    $display("FAIL sb_cnt cyc%0d dut%0d got %0d exp %0d", samp + 1, c, oc[c*8 +: 8], me.c[c*8 +: 8]);
                end
                if (samp + 1 <= 64) begin
                    obs_p[c][samp+1]  = op[c];
                    obs_f[c][samp+1]  = of[c];
                    obs_s[c][samp+1]  = os[c];
                    obs_pe[c][samp+1] = ope[c];
                    obs_c[c][samp+1]  = int'(oc[c*8 +: 8]);
                end
            end
        end
    end

    // Samples 0..n-1 from the masks, then one reset sample to close the trace
    task automatic run_trace(input bit [63:0] tv, input bit [63:0] rv, input bit [63:0] rlo, input int n);
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k <= 64; k++) begin
                obs_p[c][k] = 1'bx; obs_f[c][k] = 1'bx; obs_s[c][k] = 1'bx;
                obs_pe[c][k] = 1'bx; obs_c[c][k] = -1;
            end
        end
        for (int t = 0; t < n; t++) drive(!rlo[t], tv[t], rv[t], t);
        drive(1'b0, 1'b0, 1'b0, n);
        @(posedge clk);
        #2;
    endtask

    bit [63:0] rst01 = 64'h3;

    task automatic test_reset();
        bit [63:0] tv;
        tv = '0; tv[0] = 1; tv[1] = 1; tv[2] = 1;
        run_trace(tv, '0, rst01, 3);
        for (int c = 0; c < 3; c++) begin
            for (int k = 1; k <= 2; k++) begin
                n_checks++;
                if ({obs_p[c][k], obs_f[c][k], obs_s[c][k], obs_pe[c][k]} !== 4'b0 || obs_c[c][k] != 0) begin
                    n_errors++;
                    $display("FAIL reset_state cyc%0d dut%0d got p%b f%b s%b pe%b cnt%0d exp all 0",
                             k, c, obs_p[c][k], obs_f[c][k], obs_s[c][k], obs_pe[c][k], obs_c[c][k]);
                end
            end
        end
        n_checks++;
        if (obs_pe[0][3] !== 1'b1) begin
            n_errors++;
            $display("FAIL first_trig_pending got %b exp 1", obs_pe[0][3]);
        end
    endtask

    task automatic test_clean();
        bit [63:0] tv, rv, pm;
        tv = '0; rv = '0; pm = '0;
        tv[2] = 1; tv[5] = 1; tv[8] = 1; tv[16] = 1;
        rv[3] = 1; rv[7] = 1; rv[9] = 1; rv[10] = 1; rv[12] = 1; rv[13] = 1;
        rv[14] = 1; rv[15] = 1; rv[17] = 1;
        pm[4] = 1; pm[8] = 1; pm[10] = 1; pm[18] = 1;
        run_trace(tv, rv, rst01, 19);
        for (int k = 1; k <= 19; k++) begin
            n_checks += 2;
            if (obs_p[0][k] !== pm[k]) begin
                n_errors++;
                $display("FAIL clean_pass cyc%0d got %b exp %b", k, obs_p[0][k], pm[k]);
            end
            if (obs_f[0][k] !== 1'b0) begin
                n_errors++;
                $display("FAIL clean_fail cyc%0d got %b exp 0", k, obs_f[0][k]);
            end
        end
        n_checks++;
        if (obs_c[0][19] != 0) begin
            n_errors++;
            $display("FAIL clean_cnt got %0d exp 0", obs_c[0][19]);
        end
    endtask

    task automatic test_missing();
        bit [63:0] tv, rv;
        tv = '0; rv = '0;
        tv[2] = 1; tv[5] = 1; tv[8] = 1; tv[16] = 1;
        rv[3] = 1; rv[7] = 1; rv[9] = 1; rv[10] = 1; rv[12] = 1; rv[13] = 1;
        rv[14] = 1; rv[15] = 1;
        run_trace(tv, rv, rst01, 20);
        for (int k = 1; k <= 20; k++) begin
            n_checks++;
            if (obs_f[0][k] !== (k == 19)) begin
                n_errors++;
                $display("FAIL missing_fail cyc%0d got %b exp %b", k, obs_f[0][k], (k == 19));
            end
        end
        for (int k = 19; k <= 20; k++) begin
            n_checks += 2;
            if (obs_c[0][k] != 1) begin
                n_errors++;
                $display("FAIL missing_cnt cyc%0d got %0d exp 1", k, obs_c[0][k]);
            end
            if (obs_s[0][k] !== 1'b1) begin
                n_errors++;
                $display("FAIL missing_sticky cyc%0d got %b exp 1", k, obs_s[0][k]);
            end
        end
    endtask

    task automatic test_tail();
        bit [63:0] tv, rv;
        tv = '0; rv = '0;
        tv[2] = 1; tv[5] = 1; tv[8] = 1; tv[16] = 1; tv[19] = 1;
        rv[3] = 1; rv[7] = 1; rv[9] = 1; rv[10] = 1; rv[12] = 1; rv[13] = 1;
        rv[14] = 1; rv[15] = 1; rv[17] = 1;
        run_trace(tv, rv, rst01, 20);
        n_checks++;
        if (obs_pe[0][20] !== 1'b1) begin
            n_errors++;
            $display("FAIL tail_pending got %b exp 1", obs_pe[0][20]);
        end
        for (int k = 1; k <= 20; k++) begin
            n_checks++;
            if (obs_f[0][k] !== 1'b0) begin
                n_errors++;
                $display("FAIL tail_fail cyc%0d got %b exp 0", k, obs_f[0][k]);
            end
        end
    endtask

    task automatic test_shared();
        bit [63:0] tv, rv;
        tv = '0; rv = '0;
        tv[4] = 1; tv[5] = 1; rv[6] = 1;
        run_trace(tv, rv, rst01, 10);
        for (int k = 1; k <= 10; k++) begin
            n_checks += 2;
            if (obs_p[0][k] !== (k == 7)) begin
                n_errors++;
                $display("FAIL shared_pass cyc%0d got %b exp %b", k, obs_p[0][k], (k == 7));
            end
            if (obs_f[0][k] !== 1'b0) begin
                n_errors++;
                $display("FAIL shared_fail cyc%0d got %b exp 0", k, obs_f[0][k]);
            end
            if (k >= 7) begin
                n_checks++;
                if (obs_pe[0][k] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL shared_pending cyc%0d got %b exp 0", k, obs_pe[0][k]);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        bit [63:0] tv, rl;
        tv = '0; rl = rst01;
        tv[4] = 1; rl[5] = 1;
        run_trace(tv, '0, rl, 10);
        for (int c = 0; c < 3; c++) begin
            for (int k = 6; k <= 10; k++) begin
                n_checks++;
                if ({obs_p[c][k], obs_f[c][k], obs_s[c][k], obs_pe[c][k]} !== 4'b0 || obs_c[c][k] != 0) begin
                    n_errors++;
                    $display("FAIL abort_zero cyc%0d dut%0d got p%b f%b s%b pe%b cnt%0d exp all 0",
                             k, c, obs_p[c][k], obs_f[c][k], obs_s[c][k], obs_pe[c][k], obs_c[c][k]);
                end
            end
        end
    endtask

    task automatic test_window_edge();
        bit [63:0] tv, rv;
        tv = '0; rv = '0;
        tv[4] = 1; rv[5] = 1;
        run_trace(tv, rv, rst01, 10);
        for (int k = 1; k <= 10; k++) begin
            n_checks += 2;
            if (obs_p[1][k] !== 1'b0) begin
                n_errors++;
                $display("FAIL edge_pass cyc%0d got %b exp 0", k, obs_p[1][k]);
            end
            if (obs_f[1][k] !== (k == 8)) begin
                n_errors++;
                $display("FAIL edge_fail cyc%0d got %b exp %b", k, obs_f[1][k], (k == 8));
            end
        end
    endtask

    task automatic test_saturation();
        bit [63:0] tv;
        int exp_cnt[5] = '{1, 2, 3, 3, 3};
        int cyc;
        tv = '0;
        for (int i = 0; i < 5; i++) tv[4 + 4*i] = 1;
        run_trace(tv, '0, rst01, 24);
        for (int i = 0; i < 5; i++) begin
            cyc = 7 + 4*i;
            n_checks += 2;
            if (obs_c[2][cyc] != exp_cnt[i]) begin
                n_errors++;
                $display("FAIL sat_cnt cyc%0d got %0d exp %0d", cyc, obs_c[2][cyc], exp_cnt[i]);
            end
            if (obs_f[2][cyc] !== 1'b1) begin
                n_errors++;
                $display("FAIL sat_fail cyc%0d got %b exp 1", cyc, obs_f[2][cyc]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit [63:0] tv, rv;
        tv = '0; rv = '0;
        tv[4] = 1; tv[5] = 1; tv[6] = 1; rv[8] = 1;
        run_trace(tv, rv, rst01, 11);
        for (int k = 1; k <= 11; k++) begin
            n_checks += 2;
            if (obs_f[0][k] !== (k == 7 || k == 8)) begin
                n_errors++;
                $display("FAIL b2b_fail cyc%0d got %b exp %b", k, obs_f[0][k], (k == 7 || k == 8));
            end
            if (obs_p[0][k] !== (k == 9)) begin
                n_errors++;
                $display("FAIL b2b_pass cyc%0d got %b exp %b", k, obs_p[0][k], (k == 9));
            end
        end
        n_checks++;
        if (obs_c[0][9] != 2) begin
            n_errors++;
            $display("FAIL b2b_cnt got %0d exp 2", obs_c[0][9]);
        end
    endtask

    task automatic test_random();
        bit [63:0] tv, rv, rl;
        for (int t = 0; t < 60; t++) begin
            tv[t] = ($urandom_range(0, 1) == 1);
            rv[t] = ($urandom_range(0, 9) < 3);
            rl[t] = (t < 2) || ($urandom_range(0, 19) == 0);
        end
        tv[63:60] = '0; rv[63:60] = '0; rl[63:60] = '0;
        run_trace(tv, rv, rl, 60);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_missing();
        test_tail();
        test_shared();
        test_reset_abort();
        test_window_edge();
        test_saturation();
        test_back_to_back();
        test_random();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain got %0d exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
